dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory-side end of the CPU load/store interface (MemRead, MemWrite, Address, WriteData, mode).
- Accepts one request at a time and inserts WAIT_CYCLES wait states before responding.
- Signals completion with a one-cycle Ready pulse carrying ReadData or an error flag.
- Sits between the CPU datapath and backing storage; lets the core be tested against non-zero-latency memory.

---
 rtl/dmem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data-memory responder for a CPU load/store port. It accepts
//   one request at a time, spends WAIT_CYCLES cycles in WAIT, and then
//   answers with a one-cycle Ready pulse carrying ReadData or AddrErr.
//   Word accesses must be 4-byte aligned. Byte accesses are little-endian,
//   with lane 0 = bits 7:0.
//
//   Build option: define DMEM_SIGN_EXT_EN to sign-extend byte reads.
//   Without it, byte reads are zero-extended.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   MemRead   in   read request, sampled in IDLE
//   MemWrite  in   write request, sampled in IDLE
//   Address   in   byte address
//   WriteData in   store data; byte stores use WriteData[7:0]
//   mode      in   0 = word access, 1 = byte access
//   ReadData  out  load result, valid while Ready = 1 (otherwise 0)
//   Ready     out  one-cycle completion pulse
//   Busy      out  high from the cycle after acceptance through the Ready cycle
//   AddrErr   out  request rejected; valid with Ready
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Ready,
    output logic                  Busy,
    output logic                  AddrErr
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    accept;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    mode_q;
    logic                    rd_q;
    logic                    wr_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    // The response is built on the edge that enters RESP. With zero wait
    // states, that edge is also the acceptance edge, so the request is taken
    // straight from the inputs while in IDLE. Otherwise it comes from the
    // latched copy.
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    sel_mode;
    logic                    sel_rd;
    logic                    sel_wr;
    logic                    sel_err;
    logic [IDX_W-1:0]        sel_idx;
    logic [DATA_WIDTH-1:0]   sel_word;
    logic [7:0]              sel_byte;
    logic [DATA_WIDTH-1:0]   rd_val;

    logic                    mem_we;
    logic [IDX_W-1:0]        widx;
    logic [1:0]              wlane;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        cnt_next   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (cnt <= CNT_W'(1)) begin
                    next_state = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- request latch ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            mode_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= Address;
            wdata_q <= WriteData;
            mode_q  <= mode;
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
        end
    end

    // ---------------- response datapath ----------------
    always_comb begin
        if (state == IDLE) begin
            sel_addr = Address;
            sel_mode = mode;
            sel_rd   = MemRead;
            sel_wr   = MemWrite;
        end else begin
            sel_addr = addr_q;
            sel_mode = mode_q;
            sel_rd   = rd_q;
            sel_wr   = wr_q;
        end

        sel_err = (sel_rd && sel_wr)
                || (!sel_mode && (sel_addr[1:0] != 2'b00))
                || ({1'b0, sel_addr} >= BYTE_LIMIT);

        sel_idx  = sel_addr[IDX_W+1:2];
        sel_word = mem[sel_idx];
        sel_byte = sel_word[{sel_addr[1:0], 3'b000} +: 8];

`ifdef DMEM_SIGN_EXT_EN
        rd_val = sel_mode ? {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte} : sel_word;
`else
        rd_val = sel_mode ? {{(DATA_WIDTH-8){1'b0}}, sel_byte} : sel_word;
`endif
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ReadData <= '0;
            Ready    <= 1'b0;
            Busy     <= 1'b0;
            AddrErr  <= 1'b0;
        end else begin
            Ready   <= (next_state == RESP);
            Busy    <= (next_state != IDLE);
            AddrErr <= (next_state == RESP) && sel_err;
            if ((next_state == RESP) && sel_rd && !sel_err)
                ReadData <= rd_val;
            else
                ReadData <= '0;
        end
    end

    // ---------------- storage ----------------
    // The write commits on the edge that leaves RESP. Reset forces IDLE, so
    // an aborted request never gets here. AddrErr is still valid in RESP and
    // also covers the case where read and write were both requested.
    assign mem_we = (state == RESP) && wr_q && !AddrErr;
    assign widx   = addr_q[IDX_W+1:2];
    assign wlane  = addr_q[1:0];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (mode_q)
                mem[widx][{wlane, 3'b000} +: 8] <= wdata_q[7:0];
            else
                mem[widx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// Instance dut uses the default WAIT_CYCLES = 2.
// Instance dut0 uses WAIT_CYCLES = 0.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, mode;
    logic [31:0] Address, WriteData, ReadData;
    logic        Ready, Busy, AddrErr;

    logic        z_MemRead, z_MemWrite, z_mode;
    logic [31:0] z_Address, z_WriteData, z_ReadData;
    logic        z_Ready, z_Busy, z_AddrErr;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DMEM_SIGN_EXT_EN
    localparam logic [31:0] EXP_AA = 32'hFFFF_FFAA;
    localparam logic [31:0] EXP_A5 = 32'hFFFF_FFA5;
`else
    localparam logic [31:0] EXP_AA = 32'h0000_00AA;
    localparam logic [31:0] EXP_A5 = 32'h0000_00A5;
`endif

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .Address(Address),
        .WriteData(WriteData),
        .mode(mode),
        .ReadData(ReadData),
        .Ready(Ready),
        .Busy(Busy),
        .AddrErr(AddrErr)
    );

    dmem_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .MemRead(z_MemRead),
        .MemWrite(z_MemWrite),
        .Address(z_Address),
        .WriteData(z_WriteData),
        .mode(z_mode),
        .ReadData(z_ReadData),
        .Ready(z_Ready),
        .Busy(z_Busy),
        .AddrErr(z_AddrErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on dut, then wait (bounded) for Ready.
    // The task returns at the falling edge of the Ready cycle.
    task automatic xact(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic md,
                        output logic [31:0] rdat, output logic err);
        int lat;
        lat  = -1;
        rdat = 32'hxxxx_xxxx;
        err  = 1'bx;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Address = a; WriteData = wd; mode = md;
        @(posedge clk);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Ready) begin
                lat  = i;
                rdat = ReadData;
                err  = AddrErr;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_ready"}, Ready, 1'b1);
        chk({tag, "_latency"}, 32'(lat), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          first, second;

        rst = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0; mode = 1'b0;
        z_MemRead = 1'b0; z_MemWrite = 1'b0; z_Address = '0; z_WriteData = '0; z_mode = 1'b0;
        repeat (3) @(negedge clk);

        // Outputs while reset is held.
        chk("rst_ready", Ready, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_addrerr", AddrErr, 1'b0);
        chk("rst_readdata", ReadData, 32'h0);
        rst = 1'b1;

        // Cycle-by-cycle latency of a word write to 0x10.
        @(negedge clk);
        MemWrite = 1'b1; Address = 32'h10; WriteData = 32'hDEAD_BEEF; mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0;
        chk("lat_n1_busy", Busy, 1'b1);
        chk("lat_n1_ready", Ready, 1'b0);
        @(negedge clk);
        chk("lat_n2_busy", Busy, 1'b1);
        chk("lat_n2_ready", Ready, 1'b0);
        @(negedge clk);
        chk("lat_n3_busy", Busy, 1'b1);
        chk("lat_n3_ready", Ready, 1'b1);
        chk("lat_n3_addrerr", AddrErr, 1'b0);
        chk("lat_n3_wrdata", ReadData, 32'h0);
        @(negedge clk);
        chk("lat_n4_busy", Busy, 1'b0);
        chk("lat_n4_ready", Ready, 1'b0);

        xact("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
        chk("rd10_data", rd, 32'hDEAD_BEEF);
        chk("rd10_err", er, 1'b0);

        // Byte lanes.
        xact("wr20", 1'b0, 1'b1, 32'h20, 32'h1122_3344, 1'b0, rd, er);
        chk("wr20_data", rd, 32'h0);
        chk("wr20_err", er, 1'b0);
        xact("wb22", 1'b0, 1'b1, 32'h22, 32'h1234_56AA, 1'b1, rd, er);
        chk("wb22_err", er, 1'b0);
        xact("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, rd, er);
        chk("rd20_data", rd, 32'h11AA_3344);
        xact("rb23", 1'b1, 1'b0, 32'h23, 32'h0, 1'b1, rd, er);
        chk("rb23_data", rd, 32'h0000_0011);
        xact("rb21", 1'b1, 1'b0, 32'h21, 32'h0, 1'b1, rd, er);
        chk("rb21_data", rd, 32'h0000_0033);
        chk("rb21_err", er, 1'b0);
        xact("rb22", 1'b1, 1'b0, 32'h22, 32'h0, 1'b1, rd, er);
        chk("rb22_data", rd, EXP_AA);

        // Error cases.
        xact("rw21", 1'b1, 1'b0, 32'h21, 32'h0, 1'b0, rd, er);
        chk("rw21_err", er, 1'b1);
        chk("rw21_data", rd, 32'h0);
        xact("wr00", 1'b0, 1'b1, 32'h0, 32'h0102_0304, 1'b0, rd, er);
        xact("wr400", 1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, 1'b0, rd, er);
        chk("wr400_err", er, 1'b1);
        xact("wb401", 1'b0, 1'b1, 32'h401, 32'h0000_00EE, 1'b1, rd, er);
        chk("wb401_err", er, 1'b1);
        xact("rd00", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rd, er);
        chk("rd00_data", rd, 32'h0102_0304);
        xact("rd400", 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, rd, er);
        chk("rd400_err", er, 1'b1);
        chk("rd400_data", rd, 32'h0);
        xact("wr3fc", 1'b0, 1'b1, 32'h3FC, 32'hA5A5_0FF0, 1'b0, rd, er);
        chk("wr3fc_err", er, 1'b0);
        xact("rb3ff", 1'b1, 1'b0, 32'h3FF, 32'h0, 1'b1, rd, er);
        chk("rb3ff_data", rd, EXP_A5);
        chk("rb3ff_err", er, 1'b0);
        xact("both", 1'b1, 1'b1, 32'h10, 32'h0, 1'b0, rd, er);
        chk("both_err", er, 1'b1);
        chk("both_data", rd, 32'h0);
        xact("rd10b", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
        chk("rd10b_data", rd, 32'hDEAD_BEEF);

        // MemRead held high: a new request every WAIT_CYCLES+2 cycles.
        first = -1; second = -1;
        @(negedge clk);
        MemRead = 1'b1; Address = 32'h10; mode = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (Ready) begin
                if (first < 0) first = c;
                else begin
                    second = c;
                    rd = ReadData;
                    break;
                end
            end
        end
        MemRead = 1'b0;
        chk("b2b_first", 32'(first), 32'd2);
        chk("b2b_second", 32'(second), 32'd6);
        chk("b2b_data", rd, 32'hDEAD_BEEF);
        for (int c = 0; c < 10; c++) begin
            if (!Busy) break;
            @(negedge clk);
        end
        chk("b2b_idle", Busy, 1'b0);

        // A write pulsed during WAIT is ignored.
        // Inputs changed after acceptance have no effect.
        @(negedge clk);
        MemRead = 1'b1; Address = 32'h20; mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; WriteData = 32'h0;
        chk("ign_busy", Busy, 1'b1);
        @(negedge clk);
        MemWrite = 1'b0; Address = 32'h24; mode = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (Ready) break;
            @(negedge clk);
        end
        chk("ign_ready", Ready, 1'b1);
        chk("ign_data", ReadData, 32'h11AA_3344);
        xact("ign_rd", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, rd, er);
        chk("ign_rd_data", rd, 32'h11AA_3344);

        // Zero wait states: Ready in the cycle right after acceptance.
        @(negedge clk);
        z_MemWrite = 1'b1; z_Address = 32'h8; z_WriteData = 32'h5A5A_5A5A; z_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        z_MemWrite = 1'b0;
        chk("z_wr_ready", z_Ready, 1'b1);
        chk("z_wr_busy", z_Busy, 1'b1);
        chk("z_wr_err", z_AddrErr, 1'b0);
        @(negedge clk);
        chk("z_idle_ready", z_Ready, 1'b0);
        chk("z_idle_busy", z_Busy, 1'b0);
        z_MemRead = 1'b1; z_Address = 32'h8;
        @(posedge clk);
        @(negedge clk);
        z_MemRead = 1'b0;
        chk("z_rd_ready", z_Ready, 1'b1);
        chk("z_rd_data", z_ReadData, 32'h5A5A_5A5A);
        @(negedge clk);
        z_MemRead = 1'b1; z_Address = 32'h6; z_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        z_MemRead = 1'b0;
        chk("z_mis_err", z_AddrErr, 1'b1);
        chk("z_mis_data", z_ReadData, 32'h0);

        // Reset during WAIT aborts the pending write.
        xact("wr30", 1'b0, 1'b1, 32'h30, 32'h0000_0055, 1'b0, rd, er);
        @(negedge clk);
        MemWrite = 1'b1; Address = 32'h30; WriteData = 32'h0000_0077; mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0;
        chk("mid_busy_pre", Busy, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("mid_busy", Busy, 1'b0);
        chk("mid_ready", Ready, 1'b0);
        chk("mid_addrerr", AddrErr, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        xact("rd30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, rd, er);
        chk("rd30_data", rd, 32'h0000_0055);
        chk("rd30_err", er, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
